// File: rtl/rgb_pwm_gen.sv
// Three-channel PWM generator with double-buffered per-channel duty/mode
// and an optional breathe ramp that steps once per 256-step PWM period.
module rgb_pwm_gen #(
  parameter int unsigned PRESCALE   = 12,
  parameter int unsigned BREATHE_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_chan,
  input  logic [7:0] cfg_duty,
  input  logic       cfg_mode,
  output logic [2:0] rgb_pwm,
  output logic       period_tick
);

  localparam int unsigned PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned NCH = 3;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic {ST_UP = 1'b0, ST_DOWN = 1'b1} breathe_st_e;

  logic [PW-1:0]    r_presc;
  logic [7:0]       r_phase;
  logic             r_tick;
  logic [NCH-1:0]   r_pwm;
  logic [7:0]       r_sh_duty  [NCH];
  logic [NCH-1:0]   r_sh_mode;
  logic [7:0]       r_act_duty [NCH];
  logic [NCH-1:0]   r_act_mode;
  logic [7:0]       r_level    [NCH];
  breathe_st_e      r_state    [NCH];

  logic             w_step;
  logic             w_boundary;
  logic             w_wr;
  logic             w_mode_in;
  logic [7:0]       w_level_nxt [NCH];
  breathe_st_e      w_state_nxt [NCH];
  logic [7:0]       w_level_eff [NCH];
  logic [NCH-1:0]   w_pwm_nxt;

  assign w_step      = enable && (r_presc == PRESC_MAX);
  assign w_boundary  = w_step && (r_phase == 8'hFF);
  // Writes are refused on the boundary so shadow never changes while it is copied.
  assign cfg_ready   = rst_n && !w_boundary;
  assign w_wr        = cfg_valid && cfg_ready;
  assign w_mode_in   = (BREATHE_EN != 0) && cfg_mode;
  assign rgb_pwm     = r_pwm;
  assign period_tick = r_tick;

  // Breathe FSM next state/level, evaluated against the shadow values that
  // become active at this boundary.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_level_nxt[i] = r_level[i];
      w_level_eff[i] = r_act_mode[i] ? r_level[i] : r_act_duty[i];
      w_pwm_nxt[i]   = enable && (r_phase < w_level_eff[i]);
      if (!enable) begin
        w_state_nxt[i] = ST_UP;
        w_level_nxt[i] = 8'd0;
      end else if (w_boundary) begin
        if (!r_sh_mode[i] || !r_act_mode[i] || (r_sh_duty[i] == 8'd0)) begin
          w_state_nxt[i] = ST_UP;
          w_level_nxt[i] = 8'd0;
        end else if (r_level[i] > r_sh_duty[i]) begin
          w_state_nxt[i] = ST_DOWN;
          w_level_nxt[i] = r_sh_duty[i];
        end else begin
          case (r_state[i])
            ST_UP: begin
              if (r_level[i] >= r_sh_duty[i]) begin
                w_state_nxt[i] = ST_DOWN;
                w_level_nxt[i] = r_sh_duty[i];
              end else begin
                w_level_nxt[i] = r_level[i] + 8'd1;
                if ((r_level[i] + 8'd1) >= r_sh_duty[i]) w_state_nxt[i] = ST_DOWN;
              end
            end
            ST_DOWN: begin
              if (r_level[i] <= 8'd1) begin
                w_level_nxt[i] = 8'd0;
                w_state_nxt[i] = ST_UP;
              end else begin
                w_level_nxt[i] = r_level[i] - 8'd1;
              end
            end
            default: begin
              w_state_nxt[i] = ST_UP;
              w_level_nxt[i] = 8'd0;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_phase    <= 8'd0;
      r_tick     <= 1'b0;
      r_pwm      <= '0;
      r_sh_mode  <= '0;
      r_act_mode <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_sh_duty[i]  <= 8'd0;
        r_act_duty[i] <= 8'd0;
        r_level[i]    <= 8'd0;
        r_state[i]    <= ST_UP;
      end
    end else begin
      if (!enable) begin
        r_presc <= '0;
        r_phase <= 8'd0;
      end else if (w_step) begin
        r_presc <= '0;
        r_phase <= r_phase + 8'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      r_tick <= w_boundary;
      r_pwm  <= w_pwm_nxt;
      for (int i = 0; i < NCH; i++) begin
        if (w_wr && ((cfg_chan == 2'(i)) || (cfg_chan == 2'd3))) begin
          r_sh_duty[i] <= cfg_duty;
          r_sh_mode[i] <= w_mode_in;
        end
        // Disabled: track shadow continuously so re-enable starts with it.
        if (!enable || w_boundary) begin
          r_act_duty[i] <= r_sh_duty[i];
          r_act_mode[i] <= r_sh_mode[i];
        end
        r_level[i] <= w_level_nxt[i];
        r_state[i] <= w_state_nxt[i];
      end
    end
  end

endmodule

// File: doc/rgb_pwm_gen.md
RGB_PWM_GEN -- requirements
Module: rgb_pwm_gen

Interface
REQ-001 Parameter PRESCALE, default 12: clk cycles per PWM step, legal 1..4096.
REQ-002 Parameter BREATHE_EN, default 1: 1 enables breathe mode, 0 makes cfg_mode ignored (always steady).
REQ-003 clk  in  1  single clock domain for all logic.
REQ-004 rst_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-005 enable  in  1  1 = PWM running, 0 = outputs low and counters held.
REQ-006 cfg_valid  in  1  configuration write request.
REQ-007 cfg_ready  out  1  configuration write accepted when high with cfg_valid.
REQ-008 cfg_chan  in  2  target channel 0/1/2, 3 = all three channels.
REQ-009 cfg_duty  in  8  target duty, high steps per 256-step period.
REQ-010 cfg_mode  in  1  0 = steady, 1 = breathe.
REQ-011 rgb_pwm  out  3  PWM drive, bit i = channel i, feeds the RGBA driver stage PWM inputs.
REQ-012 period_tick  out  1  one-cycle pulse on each PWM period boundary.

Function
REQ-013 Prescaler counts 0..PRESCALE-1 and wraps; step strobe asserts on the cycle it equals PRESCALE-1.
REQ-014 8-bit phase counter increments on each step strobe, wraps 255->0; period = 256*PRESCALE clk cycles.
REQ-015 Boundary = step strobe while phase==255; period_tick is registered and asserts the cycle after the boundary.
REQ-016 Handshake: write occurs on cycle where cfg_valid && cfg_ready; writes shadow_duty and shadow_mode of selected channel(s) only.
REQ-017 cfg_ready = 0 on the boundary cycle and while rst_n low; otherwise 1; cfg_valid held across a boundary is accepted next cycle.
REQ-018 Active duty and mode load from shadow only at a boundary; mid-period writes never alter the current period.
REQ-019 rgb_pwm[i] registered: high iff enable && phase < level[i]; one clk latency from phase change.
REQ-020 level 0 -> output constantly low; level 255 -> high 255 of 256 steps.
REQ-021 Steady mode: level[i] = active duty[i].
REQ-022 Breathe per-channel FSM: UP, DOWN; at each boundary UP increments level until level >= duty then goes DOWN; DOWN decrements until level == 0 then goes UP.
REQ-023 Breathe with duty 0: level stays 0, FSM stays UP.
REQ-024 Switching breathe->steady at a boundary: level jumps to duty; steady->breathe: FSM enters UP from level 0.
REQ-025 Duty lowered below current level in breathe: next boundary FSM goes DOWN, level clamps to new duty.
REQ-026 enable low: prescaler, phase and period_tick cleared/held, rgb_pwm = 0, writes still accepted, active := shadow every cycle, breathe level 0, FSM UP.
REQ-027 enable rising: first period starts at phase 0 with loaded active values.
REQ-028 Simultaneous write and boundary impossible by REQ-017; cfg_chan=3 writes all channels identically in one cycle.

Reset
REQ-029 While rst_n low: prescaler, phase, shadow/active duty, mode, level = 0; FSM UP; rgb_pwm = 3'b000; period_tick = 0; cfg_ready = 0.
REQ-030 First cycle after rst_n high: cfg_ready = 1; reset mid-period discards period and pending writes.

Verification
REQ-031 PRESCALE=1, enable=1, write ch0 duty=64 steady -> from next boundary rgb_pwm[0] high 64 of each 256 cycles, period_tick every 256 cycles.
REQ-032 Write ch1 duty=200 at phase 100 -> current period unchanged, next period high 200 cycles; cfg_ready low only on boundary cycle.
REQ-033 cfg_chan=3 duty=0 then duty=255 -> all bits low a full period, then high 255/256 cycles.
REQ-034 Breathe ch2 duty=3 -> per-period high counts 1,2,3,2,1,0,1,... .
REQ-035 enable dropped at phase 50 -> rgb_pwm=0 next cycle, counters hold 0; re-enable -> phase restarts at 0.
REQ-036 rst_n low mid-period with duty=128 -> next cycle all outputs 0, cfg_ready 0; after release duty reads back 0 (outputs stay low).
